// File: rtl/cpu_consts.sv
// cpu_consts: shared fetch types and constants; FAULT state is only built with PC_MISALIGN_CHK_EN
package cpu_consts;
`ifdef PC_MISALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} fetch_state_t;
`endif
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory, decode and redirect signals of the fetch unit; fetch_fault_o needs PC_MISALIGN_CHK_EN
interface instr_fetch_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
`ifdef PC_MISALIGN_CHK_EN
  logic        fetch_fault_o;
`endif
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
`ifdef PC_MISALIGN_CHK_EN
    output fetch_fault_o,
`endif
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
`ifdef PC_MISALIGN_CHK_EN
    input  fetch_fault_o,
`endif
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO with flush, head shown combinationally; push while full is accepted only with a pop
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [63:0]
) (
  input  logic                         clk_i,
  input  logic                         resetn_i,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  T                             i_data,
  input  logic                         i_pop,
  output T                             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [CW-1:0]  r_cnt;
  logic           w_pop, w_push;
  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_push  = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with PC tag queue, instruction buffer and redirect drop counting.
// Optional PC_MISALIGN_CHK_EN traps misaligned redirect targets into a FAULT state.
module instr_fetch import cpu_consts::*; #(
  parameter logic [63:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  fetch_state_t  r_state, w_next;
  logic [63:0]   r_pc;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_tag_cnt, w_dat_cnt;
  logic [CW:0]   w_out;
  logic [63:0]   w_tag_head;
  fetch_entry_t  w_dat_in, w_dat_head;
  logic          w_gnt, w_rv, w_keep, w_pop, w_room, w_valid;
  assign w_gnt    = bus.imem_req_o && bus.imem_gnt_i;
  // dropped responses still occupy memory slots, so they count as outstanding
  assign w_out    = {1'b0, w_tag_cnt} + {1'b0, r_drop};
  assign w_rv     = bus.imem_rvalid_i && (w_out != '0);
  assign w_keep   = w_rv && (r_drop == '0) && !bus.redirect_i;
  assign w_valid  = (w_dat_cnt != '0);
  assign w_pop    = w_valid && bus.instr_ready_i && !bus.redirect_i;
  assign w_room   = (w_out + {1'b0, w_dat_cnt}) < (CW+1)'(BUF_DEPTH);
  assign w_dat_in = '{pc: w_tag_head, instr: bus.imem_rdata_i};
  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(logic [63:0])) u_tags (
    .clk_i(clk_i), .resetn_i(resetn_i), .i_flush(bus.redirect_i),
    .i_push(w_gnt), .i_data(r_pc), .i_pop(w_rv && (r_drop == '0)),
    .o_data(w_tag_head), .o_count(w_tag_cnt)
  );
  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
    .clk_i(clk_i), .resetn_i(resetn_i), .i_flush(bus.redirect_i),
    .i_push(w_keep), .i_data(w_dat_in), .i_pop(w_pop),
    .o_data(w_dat_head), .o_count(w_dat_cnt)
  );
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = RUN;
`ifdef PC_MISALIGN_CHK_EN
    if (bus.redirect_i) w_next = (|bus.redirect_pc_i[1:0]) ? FAULT : RUN;
`endif
  end
  always_comb begin
    bus.imem_req_o    = (r_state == RUN) && !bus.redirect_i && w_room;
    bus.imem_addr_o   = r_pc;
    bus.instr_valid_o = w_valid;
    bus.instr_o       = w_valid ? w_dat_head.instr : NOP_INSTR;
    bus.instr_pc_o    = w_valid ? w_dat_head.pc : 64'h0;
`ifdef PC_MISALIGN_CHK_EN
    bus.fetch_fault_o = (r_state == FAULT);
`endif
  end
  // a response landing in the redirect cycle retires one of the outstanding requests
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_pc   <= RESET_PC;
      r_drop <= '0;
    end else if (bus.redirect_i) begin
      r_pc   <= bus.redirect_pc_i & ~64'h3;
      r_drop <= CW'(w_out - {{CW{1'b0}}, w_rv});
    end else begin
      if (w_gnt) r_pc <= r_pc + 64'd4;
      if (w_rv && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table and corner sequences for instr_fetch with a 1-cycle in-order memory model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(64'h0000_0000_8000_0000), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .resetn_i(rstn), .bus(bus)
  );
  typedef struct {
    bit          inj;
    bit          req;
    logic [63:0] addr;
    bit          vld;
    logic [63:0] pc;
  } vec_t;
  vec_t        tbl [9];
  logic [63:0] q [$];
  bit          hold, inj, from_q;
  int          n_chk, n_fail, grants;
  function automatic logic [31:0] expi(input logic [63:0] p);
    return ~p[31:0];
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic settle();
    from_q = !hold && (q.size() > 0);
    bus.imem_rvalid_i = from_q || inj;
    bus.imem_rdata_i  = from_q ? expi(q[0]) : 32'hDEAD_BEEF;
    #1;
  endtask
  task automatic adv();
    if (from_q) void'(q.pop_front());
    if (bus.imem_req_o && bus.imem_gnt_i) begin
      q.push_back(bus.imem_addr_o);
      grants++;
    end
    @(posedge clk);
    @(negedge clk);
    inj = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_req", {63'h0, bus.imem_req_o}, 64'h0);
    chk("rst_addr", bus.imem_addr_o, 64'h8000_0000);
    chk("rst_valid", {63'h0, bus.instr_valid_o}, 64'h0);
    chk("rst_instr", {32'h0, bus.instr_o}, 64'h13);
    chk("rst_pc", bus.instr_pc_o, 64'h0);
`ifdef PC_MISALIGN_CHK_EN
    chk("rst_fault", {63'h0, bus.fetch_fault_o}, 64'h0);
`endif
    q.delete();
    hold = 0; inj = 0; from_q = 0; grants = 0;
    bus.instr_ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 64'h0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic wait_valid(input string nm, input logic [63:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      settle();
      if (bus.instr_valid_o) seen = 1;
      else adv();
    end
    chk({nm, "_seen"}, {63'h0, seen}, 64'h1);
    chk({nm, "_pc"}, bus.instr_pc_o, exp_pc);
    chk({nm, "_instr"}, {32'h0, bus.instr_o}, {32'h0, expi(exp_pc)});
    adv();
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    n_chk = 0; n_fail = 0;
    bus.imem_gnt_i = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    bus.instr_ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 64'h0;
    tbl[0] = '{1, 0, 64'h8000_0000, 0, 64'h0};
    tbl[1] = '{0, 1, 64'h8000_0000, 0, 64'h0};
    tbl[2] = '{0, 1, 64'h8000_0004, 0, 64'h0};
    tbl[3] = '{0, 0, 64'h8000_0008, 1, 64'h8000_0000};
    tbl[4] = '{0, 1, 64'h8000_0008, 1, 64'h8000_0004};
    tbl[5] = '{0, 1, 64'h8000_000C, 0, 64'h0};
    tbl[6] = '{0, 0, 64'h8000_0010, 1, 64'h8000_0008};
    tbl[7] = '{0, 1, 64'h8000_0010, 1, 64'h8000_000C};
    tbl[8] = '{0, 1, 64'h8000_0014, 0, 64'h0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      inj = tbl[i].inj;
      settle();
      chk($sformatf("t%0d_req", i), {63'h0, bus.imem_req_o}, {63'h0, tbl[i].req});
      chk($sformatf("t%0d_addr", i), bus.imem_addr_o, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {63'h0, bus.instr_valid_o}, {63'h0, tbl[i].vld});
      chk($sformatf("t%0d_pc", i), bus.instr_pc_o, tbl[i].pc);
      chk($sformatf("t%0d_instr", i), {32'h0, bus.instr_o},
          {32'h0, tbl[i].vld ? expi(tbl[i].pc) : 32'h13});
      adv();
    end
    do_reset();
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i >= 3) begin
        chk("stall_pc", bus.instr_pc_o, 64'h8000_0000);
        chk("stall_instr", {32'h0, bus.instr_o}, {32'h0, expi(64'h8000_0000)});
      end
      adv();
    end
    settle();
    chk("stall_grants", 64'(grants), 64'd2);
    chk("stall_req", {63'h0, bus.imem_req_o}, 64'h0);
    bus.instr_ready_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 64'h8000_0200;
    settle();
    chk("rdpop_req", {63'h0, bus.imem_req_o}, 64'h0);
    adv();
    bus.redirect_i = 1'b0;
    settle();
    chk("rdpop_flushed", {63'h0, bus.instr_valid_o}, 64'h0);
    adv();
    wait_valid("rdpop_next", 64'h8000_0200);
    wait_valid("rdpop_next2", 64'h8000_0204);
    do_reset();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      adv();
    end
    settle();
    chk("drop_full_req", {63'h0, bus.imem_req_o}, 64'h0);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 64'h8000_0100;
    settle();
    chk("drop_redir_req", {63'h0, bus.imem_req_o}, 64'h0);
    adv();
    bus.redirect_i = 1'b0;
    hold = 0;
    wait_valid("drop_next", 64'h8000_0100);
    do_reset();
    settle();
    adv();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    settle();
    chk("wrap_redir_req", {63'h0, bus.imem_req_o}, 64'h0);
    adv();
    bus.redirect_i = 1'b0;
    settle();
    chk("wrap_req", {63'h0, bus.imem_req_o}, 64'h1);
    chk("wrap_addr0", bus.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    adv();
    settle();
    chk("wrap_addr1", bus.imem_addr_o, 64'h0);
    adv();
    wait_valid("wrap_first", 64'hFFFF_FFFF_FFFF_FFFC);
    do_reset();
    settle();
    adv();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 64'h8000_0102;
    settle();
    adv();
    bus.redirect_i = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("fault_flag", {63'h0, bus.fetch_fault_o}, 64'h1);
      chk("fault_req", {63'h0, bus.imem_req_o}, 64'h0);
      adv();
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 64'h8000_0200;
    settle();
    adv();
    bus.redirect_i = 1'b0;
    settle();
    chk("fault_clear", {63'h0, bus.fetch_fault_o}, 64'h0);
    chk("fault_resume_req", {63'h0, bus.imem_req_o}, 64'h1);
    chk("fault_resume_addr", bus.imem_addr_o, 64'h8000_0200);
    adv();
    wait_valid("fault_resume", 64'h8000_0200);
`else
    settle();
    chk("misal_req", {63'h0, bus.imem_req_o}, 64'h1);
    chk("misal_addr", bus.imem_addr_o, 64'h8000_0100);
    adv();
    wait_valid("misal_first", 64'h8000_0100);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
